// File: rtl/demux_20.sv
// ---------------------------------------------------------------------------
// demux_20 -- pair-to-frame demultiplexer
//
// Collects five 9-bit sample pairs into one 10-sample frame. Each pair lands
// in slot sel (in_a -> out_(2*sel), in_b -> out_(2*sel+1)). When slot 4 is
// written the frame is held on out_0..out_9 with out_valid=1 until the
// consumer takes it.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. Nothing else moves data. A producer must keep
// its payload stable while valid=1 and ready=0. ready may depend on the
// other side's signals; valid never depends on ready.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset, highest priority
//   clr        : synchronous flush of the partial or held frame
//   in_a/in_b  : even/odd sample of the offered pair (9 bits each)
//   in_valid   : pair offered
//   in_ready   : pair accepted this cycle if in_valid is also 1
//   out_0..9   : assembled frame, sample k on out_k
//   out_valid  : frame complete and held
//   out_ready  : frame consumed this cycle if out_valid is also 1
//   sel        : index of the next pair slot (0..4)
//   frame_cnt  : number of consumed frames, wraps 255 -> 0
//   dbg_state  : FSM state (0 = FILL, 1 = HOLD)
// ---------------------------------------------------------------------------
module demux_20 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [8:0] in_a,
  input  logic [8:0] in_b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] out_0,
  output logic [8:0] out_1,
  output logic [8:0] out_2,
  output logic [8:0] out_3,
  output logic [8:0] out_4,
  output logic [8:0] out_5,
  output logic [8:0] out_6,
  output logic [8:0] out_7,
  output logic [8:0] out_8,
  output logic [8:0] out_9,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] frame_cnt,
  output logic       dbg_state
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [2:0] LAST_SLOT = 3'd4;

  state_t     state;
  logic [8:0] frame [10];

  logic       accept;
  logic       consume;
  logic [2:0] wr_slot;

  // In HOLD only the consume cycle can take a pair, so the consumer's
  // ready is passed straight through. rst and clr block every acceptance.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !clr) begin
      in_ready = (state == FILL) ? 1'b1 : out_ready;
    end
  end

  always_comb begin
    accept  = in_valid & in_ready;
    consume = (state == HOLD) & out_ready & ~rst & ~clr;
    // sel is already 0 in HOLD; forcing slot 0 makes the pass-through
    // write independent of that invariant.
    wr_slot = (state == HOLD) ? 3'd0 : sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      sel       <= 3'd0;
      frame_cnt <= 8'd0;
      for (int k = 0; k < 10; k++) begin
        frame[k] <= 9'd0;
      end
    end else if (clr) begin
      // Flush drops the frame in progress (or the held frame) but leaves
      // sample storage and the frame counter alone.
      state <= FILL;
      sel   <= 3'd0;
    end else begin
      if (consume) begin
        frame_cnt <= frame_cnt + 8'd1;
        state     <= FILL;
      end
      if (accept) begin
        for (int k = 0; k < 5; k++) begin
          if (wr_slot == 3'(k)) begin
            frame[2*k]   <= in_a;
            frame[2*k+1] <= in_b;
          end
        end
        // Slot 4 completes the frame; a pass-through write is always slot
        // 0, so it can never collide with this transition.
        if (wr_slot == LAST_SLOT) begin
          sel   <= 3'd0;
          state <= HOLD;
        end else begin
          sel <= wr_slot + 3'd1;
        end
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  assign out_0 = frame[0];
  assign out_1 = frame[1];
  assign out_2 = frame[2];
  assign out_3 = frame[3];
  assign out_4 = frame[4];
  assign out_5 = frame[5];
  assign out_6 = frame[6];
  assign out_7 = frame[7];
  assign out_8 = frame[8];
  assign out_9 = frame[9];

endmodule
